sel_pipe: RTL and testbench

//  Parametrised N-way WIDTH-bit selector followed by a DEPTH-stage elastic

---
 rtl/sel_pipe.sv | 110 +++++++++++
 tb/tb_sel_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sel_pipe.sv
`default_nettype none
// ============================================================================
// sel_pipe : NUM_IN-way WIDTH-bit selector feeding a DEPTH-stage elastic
//            valid/ready pipeline with flush and sticky select-range error.
// Rev 1.0
// ============================================================================
module sel_pipe #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int DEPTH  = 1,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  logic [WIDTH-1:0] mux_data;
  logic             sel_oob;
  logic             accept;
  logic [DEPTH:0]   adv;
  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_d [DEPTH];
  logic             err_q;
  logic             err_d;

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (in_sel == SEL_W'(k)) mux_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  // Out-of-range selects only exist when NUM_IN leaves select codes unused.
  generate
    if ((1 << SEL_W) == NUM_IN) begin : g_sel_pow2
      assign sel_oob = 1'b0;
    end else begin : g_sel_range
      localparam logic [SEL_W:0] NUM_IN_W = NUM_IN[SEL_W:0];
      assign sel_oob = ({1'b0, in_sel} >= NUM_IN_W);
    end
  endgenerate

  // A stage may advance when it is empty or everything downstream moves.
  always_comb begin
    adv        = '0;
    adv[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i] = ~v_q[i] | adv[i+1];
    end
  end

  assign in_ready = adv[0] & ~flush;
  assign accept   = in_valid & in_ready;

  always_comb begin
    v_d = v_q;
    for (int i = 0; i < DEPTH; i++) d_d[i] = d_q[i];
    if (flush) begin
      v_d = '0;
    end else begin
      if (adv[0]) begin
        v_d[0] = accept;
        d_d[0] = mux_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (adv[i]) begin
          v_d[i] = v_q[i-1];
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  // Set has priority so an error accepted alongside a clear is not lost.
  always_comb begin
    err_d = err_q;
    if (err_clr)          err_d = 1'b0;
    if (accept & sel_oob) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q   <= '0;
      err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q   <= v_d;
      err_q <= err_d;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_d[i];
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign sel_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sel_pipe.sv
`default_nettype none
// ============================================================================
// tb_sel_pipe : four sel_pipe configurations on shared stimulus, each checked
//               every cycle against a queue model, plus directed literals.
// Rev 1.0
// ============================================================================
module tb_sel_pipe;

  localparam int NDUT = 4;

  typedef struct {
    logic [31:0] d;
    int          pos;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] in_data = '0;
  logic [1:0]   in_sel = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         err_clr = 1'b0;

  logic [NDUT-1:0] o_rdy;
  logic [NDUT-1:0] o_valid;
  logic [NDUT-1:0] o_err;
  logic [31:0]     o_data [NDUT];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", nm, got, want, $time);
  endtask

  // Instances: 0 = N4/D1, 1 = N4/D3, 2 = N4/D2, 3 = N3/D3
  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int NI = (k == 3) ? 3 : 4;
    localparam int DP = (k == 0) ? 1 : ((k == 2) ? 2 : 3);

    sel_pipe #(.WIDTH(32), .NUM_IN(NI), .DEPTH(DP)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_data   (in_data[NI*32-1:0]),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (o_rdy[k]),
      .out_data  (o_data[k]),
      .out_valid (o_valid[k]),
      .out_ready (out_ready),
      .sel_err   (o_err[k]),
      .err_clr   (err_clr)
    );

    // Model: oldest entry first; an entry moves one slot forward unless the
    // tail is stalled and every slot ahead of it is occupied.
    ent_t q[$];
    bit   m_err = 1'b0;
    bit   live  = 1'b0;

    always @(posedge clk) begin
      int   s;
      bit   acc;
      ent_t e;
      if (rst) begin
        q.delete();
        m_err = 1'b0;
        live  = 1'b1;
      end else if (live) begin
        s   = int'(in_sel);
        acc = in_valid && !flush && (out_ready || q.size() < DP);
        if (flush) begin
          q.delete();
        end else begin
          for (int i = 0; i < q.size(); i++)
            if (out_ready || i != DP - 1 - q[i].pos) q[i].pos++;
          if (q.size() > 0 && q[0].pos == DP) void'(q.pop_front());
          if (acc) begin
            e.d   = (s < NI) ? in_data[s*32 +: 32] : 32'h0;
            e.pos = 0;
            q.push_back(e);
          end
        end
        if (acc && s >= NI) m_err = 1'b1;
        else if (err_clr)   m_err = 1'b0;
      end
    end

    always @(negedge clk) begin
      bit ev;
      if (live && !rst) begin
        ev = (q.size() > 0) && (q[0].pos == DP - 1);
        chk($sformatf("model in_ready[%0d]", k), 32'(o_rdy[k]),
            32'(!flush && (out_ready || q.size() < DP)));
        chk($sformatf("model out_valid[%0d]", k), 32'(o_valid[k]), 32'(ev));
        if (ev) chk($sformatf("model out_data[%0d]", k), o_data[k], q[0].d);
        chk($sformatf("model sel_err[%0d]", k), 32'(o_err[k]), 32'(m_err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    flush    = 1'b0;
    err_clr  = 1'b0;
  endtask

  logic [15:0] pv;
  logic [11:0] pr;

  initial begin
    in_data = {32'h44, 32'h33, 32'h22, 32'h11};
    ticks(2);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("reset out_valid[%0d]", k), 32'(o_valid[k]), 32'h0);
      chk($sformatf("reset out_data[%0d]", k), o_data[k], 32'h0);
      chk($sformatf("reset sel_err[%0d]", k), 32'(o_err[k]), 32'h0);
      chk($sformatf("reset in_ready[%0d]", k), 32'(o_rdy[k]), 32'h1);
    end

    // single select, depth 1
    in_valid = 1'b1; in_sel = 2'd2;
    tick();
    in_valid = 1'b0;
    chk("t1 out_valid", 32'(o_valid[0]), 32'h1);
    chk("t1 out_data", o_data[0], 32'h33);
    chk("t1 sel_err", 32'(o_err[0]), 32'h0);
    ticks(3);

    // back-to-back stream, depth 3
    for (int j = 0; j < 8; j++) begin
      in_valid = (j < 4);
      in_sel   = 2'(j);
      #1;
      if (j < 4) chk("t2 in_ready", 32'(o_rdy[1]), 32'h1);
      tick();
      if (j >= 2 && j <= 5) begin
        chk("t2 out_valid", 32'(o_valid[1]), 32'h1);
        chk("t2 out_data", o_data[1], 32'h11 * (j - 1));
      end
    end
    idle_inputs();

    // backpressure, depth 2
    out_ready = 1'b0;
    in_valid = 1'b1; in_sel = 2'd1;
    tick();
    in_sel = 2'd2;
    tick();
    in_sel = 2'd3;
    #1;
    chk("t3 in_ready full", 32'(o_rdy[2]), 32'h0);
    chk("t3 out_data first", o_data[2], 32'h22);
    tick();
    chk("t3 out_data held", o_data[2], 32'h22);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("t3 drain valid", 32'(o_valid[2]), 32'h1);
    chk("t3 drain data", o_data[2], 32'h33);
    tick();
    chk("t3 drained", 32'(o_valid[2]), 32'h0);
    ticks(3);

    // out-of-range select, NUM_IN = 3
    in_valid = 1'b1; in_sel = 2'd3;
    tick();
    in_valid = 1'b0;
    chk("t4 sel_err n3", 32'(o_err[3]), 32'h1);
    chk("t4 sel_err n4", 32'(o_err[1]), 32'h0);
    ticks(2);
    chk("t4 out_valid", 32'(o_valid[3]), 32'h1);
    chk("t4 out_data zero", o_data[3], 32'h0);
    in_valid = 1'b1; err_clr = 1'b1;
    tick();
    chk("t4 set beats clr", 32'(o_err[3]), 32'h1);
    in_valid = 1'b0;
    tick();
    chk("t4 cleared", 32'(o_err[3]), 32'h0);
    err_clr = 1'b0;
    ticks(3);

    // flush with three in flight, depth 3
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      in_valid = 1'b1; in_sel = 2'(j);
      tick();
    end
    chk("t5 tail before flush", o_data[1], 32'h11);
    flush = 1'b1; in_sel = 2'd3;
    #1;
    chk("t5 in_ready flush", 32'(o_rdy[1]), 32'h0);
    tick();
    idle_inputs();
    out_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk("t5 no entry after flush", 32'(o_valid[1]), 32'h0);
      tick();
    end

    // reset while full with sel_err set
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_sel = (j == 0) ? 2'd3 : 2'(j - 1);
      tick();
    end
    chk("t6 pre sel_err", 32'(o_err[3]), 32'h1);
    chk("t6 pre out_valid", 32'(o_valid[3]), 32'h1);
    rst = 1'b1; flush = 1'b1; err_clr = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("t6 out_valid[%0d]", k), 32'(o_valid[k]), 32'h0);
      chk($sformatf("t6 out_data[%0d]", k), o_data[k], 32'h0);
      chk($sformatf("t6 sel_err[%0d]", k), 32'(o_err[k]), 32'h0);
      chk($sformatf("t6 in_ready[%0d]", k), 32'(o_rdy[k]), 32'h1);
    end

    // mixed valid / backpressure pattern checked by the model
    pv = 16'b1011_1110_0111_0101;
    pr = 12'b1100_1011_0110;
    for (int j = 0; j < 48; j++) begin
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = 32'h1000 * (j + 1) + 32'(k);
      in_valid  = pv[j % 16];
      out_ready = pr[j % 12];
      in_sel    = 2'((j * 3) % 4);
      flush     = (j == 30);
      err_clr   = (j == 40);
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    ticks(4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
